// File: rtl/fetch_bus_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter for a single req/ack memory port.
// Optional bus timeout abort is compiled in with FETCH_BUS_ARB_TIMEOUT_EN.
module fetch_bus_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_be,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              arb_en, win_if, win_ls;

`ifdef FETCH_BUS_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             tmo_hit;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign err     = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
`ifdef FETCH_BUS_ARB_TIMEOUT_EN
        err_d       = 1'b0;
        tmo_d       = (state_q == IDLE) ? tmo_q : tmo_q + 1'b1;
`endif

        // The ack cycle doubles as an arbitration slot so transfers can run back-to-back.
        arb_en = (state_q == IDLE) || mem_ack;
        win_if = arb_en && if_req && (!ls_req || starve_q == STARVE_LIM);
        win_ls = arb_en && ls_req && !win_if;

        case (state_q)
            IDLE: ;
            BUSY_IF: begin
                if (mem_ack) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata;
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                end
`ifdef FETCH_BUS_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = '0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                end
`endif
            end
            BUSY_LS: begin
                if (mem_ack) begin
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = mem_rdata;
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                end
`ifdef FETCH_BUS_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = '0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (win_if) begin
            if_gnt_d    = 1'b1;
            state_d     = BUSY_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = 4'hF;
        end else if (win_ls) begin
            ls_gnt_d    = 1'b1;
            state_d     = BUSY_LS;
            mem_req_d   = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_be_d    = ls_be;
        end
`ifdef FETCH_BUS_ARB_TIMEOUT_EN
        if (win_if || win_ls) tmo_d = '0;
`endif

        // Count LS wins only while IF is actually waiting.
        if (!if_req || win_if) begin
            starve_d = 4'd0;
        end else if (win_ls && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
`ifdef FETCH_BUS_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
`ifdef FETCH_BUS_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Directed bench for fetch_bus_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_fetch_bus_arbiter;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;

    logic              clk, rst;
    logic              if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata, ls_rdata;
    logic [3:0]        ls_be;
    logic              mem_req, mem_we, mem_ack, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [3:0]        mem_be;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk_b({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk_b({tag, "_ls_gnt"}, ls_gnt, 1'b0);
        chk_b({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        chk_b({tag, "_ls_rvalid"}, ls_rvalid, 1'b0);
        chk_b({tag, "_err"}, err, 1'b0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [6:0] exp_ls_gnt, exp_if_gnt, exp_ls_rv, exp_if_rv;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = 4'h0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) tick();

        // Reset values, then mem_ack held in IDLE with nobody requesting.
        chk_quiet("reset");
        chk_b("reset_mem_req", mem_req, 1'b0);
        chk_w("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk_w("reset_mem_be", 32'(mem_be), 32'h0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("idle_ack");
            chk_b("idle_ack_mem_req", mem_req, 1'b0);
            chk_w("idle_ack_if_rdata", if_rdata, 32'h0);
            chk_w("idle_ack_ls_rdata", ls_rdata, 32'h0);
        end
        mem_ack = 1'b0;

        // Single IF read, ack two cycles after mem_req rises.
        if_req = 1'b1; if_addr = 26'h100;
        tick();
        chk_b("t1_if_gnt", if_gnt, 1'b1);
        chk_b("t1_mem_req", mem_req, 1'b1);
        chk_w("t1_mem_addr", 32'(mem_addr), 32'h100);
        chk_w("t1_mem_be", 32'(mem_be), 32'hF);
        chk_b("t1_mem_we", mem_we, 1'b0);
        if_req = 1'b0;
        tick();
        chk_b("t1_if_gnt_pulse", if_gnt, 1'b0);
        chk_b("t1_mem_req_hold", mem_req, 1'b1);
        chk_w("t1_mem_addr_hold", 32'(mem_addr), 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk_b("t1_if_rvalid", if_rvalid, 1'b1);
        chk_w("t1_if_rdata", if_rdata, 32'h1234_5678);
        chk_b("t1_ls_rvalid", ls_rvalid, 1'b0);
        chk_b("t1_mem_req_drop", mem_req, 1'b0);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        chk_b("t1_if_rvalid_pulse", if_rvalid, 1'b0);
        chk_w("t1_if_rdata_hold", if_rdata, 32'h1234_5678);

        // Simultaneous requests: LS write first, IF granted on the LS ack cycle.
        if_req = 1'b1; if_addr = 26'h300;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 26'h200; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'h3;
        tick();
        chk_b("t2_ls_gnt", ls_gnt, 1'b1);
        chk_b("t2_if_gnt", if_gnt, 1'b0);
        chk_b("t2_mem_we", mem_we, 1'b1);
        chk_w("t2_mem_be", 32'(mem_be), 32'h3);
        chk_w("t2_mem_addr", 32'(mem_addr), 32'h200);
        chk_w("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        ls_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        chk_b("t2_ls_rvalid", ls_rvalid, 1'b1);
        chk_w("t2_ls_rdata", ls_rdata, 32'hAAAA_5555);
        chk_b("t2_if_gnt_b2b", if_gnt, 1'b1);
        chk_b("t2_mem_req_b2b", mem_req, 1'b1);
        chk_w("t2_mem_addr_if", 32'(mem_addr), 32'h300);
        chk_b("t2_mem_we_if", mem_we, 1'b0);
        chk_w("t2_mem_be_if", 32'(mem_be), 32'hF);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk_quiet("t2_wait");
        chk_b("t2_mem_req_wait", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        chk_b("t2_if_rvalid", if_rvalid, 1'b1);
        chk_w("t2_if_rdata", if_rdata, 32'h0BAD_F00D);
        chk_b("t2_mem_req_end", mem_req, 1'b0);
        mem_ack = 1'b0;

        // Starvation: both held, ack every cycle -> 4 LS, 1 IF, then LS again.
        exp_ls_gnt = 7'b110_1111;
        exp_if_gnt = 7'b001_0000;
        exp_ls_rv  = 7'b101_1110;
        exp_if_rv  = 7'b010_0000;
        if_req = 1'b1; if_addr = 26'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 26'h500; ls_be = 4'hF;
        mem_ack = 1'b1; mem_rdata = 32'h0000_00C3;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_b($sformatf("t3_ls_gnt_%0d", i), ls_gnt, exp_ls_gnt[i]);
            chk_b($sformatf("t3_if_gnt_%0d", i), if_gnt, exp_if_gnt[i]);
            chk_b($sformatf("t3_ls_rv_%0d", i), ls_rvalid, exp_ls_rv[i]);
            chk_b($sformatf("t3_if_rv_%0d", i), if_rvalid, exp_if_rv[i]);
            chk_b($sformatf("t3_mem_req_%0d", i), mem_req, 1'b1);
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        chk_b("t3_last_ls_rvalid", ls_rvalid, 1'b1);
        chk_b("t3_idle_mem_req", mem_req, 1'b0);
        chk_b("t3_idle_ls_gnt", ls_gnt, 1'b0);
        mem_ack = 1'b0;

        // Reset in BUSY_LS without ack: transaction dropped.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 26'h600; ls_be = 4'hF;
        tick();
        chk_b("t4_ls_gnt", ls_gnt, 1'b1);
        chk_w("t4_mem_addr", 32'(mem_addr), 32'h600);
        ls_req = 1'b0; rst = 1'b1;
        tick();
        chk_b("t4_rst_mem_req", mem_req, 1'b0);
        chk_quiet("t4_rst");
        rst = 1'b0;
        tick();
        chk_b("t4_post_ls_rvalid", ls_rvalid, 1'b0);
        chk_b("t4_post_mem_req", mem_req, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        chk_quiet("t4_stray_ack");
        chk_w("t4_ls_rdata_reset", ls_rdata, 32'h0);
        mem_ack = 1'b0;
        if_req = 1'b1; if_addr = 26'h700;
        tick();
        chk_b("t4_if_gnt", if_gnt, 1'b1);
        chk_w("t4_if_mem_addr", 32'(mem_addr), 32'h700);
        // LS request withdrawn before the arbitration slot: never granted.
        if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 26'h900;
        tick();
        chk_b("t4_busy_ls_gnt", ls_gnt, 1'b0);
        ls_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5A5A_A5A5;
        tick();
        chk_b("t4_if_rvalid", if_rvalid, 1'b1);
        chk_w("t4_if_rdata", if_rdata, 32'h5A5A_A5A5);
        chk_b("t4_no_ls_gnt", ls_gnt, 1'b0);
        chk_b("t4_end_mem_req", mem_req, 1'b0);
        mem_ack = 1'b0;
        tick();
        chk_quiet("t4_end");

`ifdef FETCH_BUS_ARB_TIMEOUT_EN
        // Unacked IF read aborts 64 cycles after grant.
        if_req = 1'b1; if_addr = 26'h800;
        tick();
        chk_b("t5_if_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        for (int i = 2; i <= 64; i++) begin
            tick();
            chk_b($sformatf("t5_wait_req_%0d", i), mem_req, 1'b1);
            chk_b($sformatf("t5_wait_rv_%0d", i), if_rvalid, 1'b0);
        end
        tick();
        chk_b("t5_abort_rvalid", if_rvalid, 1'b1);
        chk_b("t5_abort_err", err, 1'b1);
        chk_w("t5_abort_rdata", if_rdata, 32'h0);
        chk_b("t5_abort_mem_req", mem_req, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        chk_quiet("t5_late_ack");
        chk_w("t5_late_rdata", if_rdata, 32'h0);
        mem_ack = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_bus_arbiter.md
Name: fetch_bus_arbiter

Overview:
- Shares the single external memory port between two requesters: the instruction fetcher (IF) and the load/store unit (LS).
- Sits between the core (fetch stage, memory stage) and the memory/bus interface.
- Sequences one outstanding transaction at a time with a req/ack handshake.
- Priority: LS is favoured; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_W, 26, byte address width.
- DATA_W, 32, data bus width.
- STARVE_MAX, 4, number of consecutive LS grants while IF waits before IF is forced to win (1..15).
- TIMEOUT, 64, cycles to wait for mem_ack before abort (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  IF read request; held until if_gnt.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  one-cycle pulse: IF request captured.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  IF read data.
- ls_req  in  1  LS request; held until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_W  LS address.
- ls_wdata  in  DATA_W  LS write data.
- ls_be  in  4  LS byte enables.
- ls_gnt  out  1  one-cycle pulse: LS request captured.
- ls_rvalid  out  1  one-cycle pulse: LS access complete (read data valid; also pulses for writes).
- ls_rdata  out  DATA_W  LS read data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  4  memory byte enables (IF always 4'b1111).
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- err  out  1  one-cycle pulse with rvalid when the access was aborted.

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0.
- Reset asserted mid-transaction: mem_req drops at that edge, the transaction is discarded, no rvalid is issued.
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- Arbitration occurs in IDLE, and in a BUSY state on the mem_ack cycle (back-to-back transfers).
  - Winner = IF if if_req && (!ls_req || starve_cnt == STARVE_MAX); otherwise LS if ls_req.
- On grant (registered, edge after arbitration):
  - gnt pulses for 1 cycle.
  - addr/we/wdata/be are captured into mem_* and mem_req is asserted.
  - State becomes BUSY_IF or BUSY_LS.
- mem_* outputs are stable while mem_req=1 && !mem_ack.
- On mem_ack in BUSY_x, at the next edge:
  - x_rvalid pulses.
  - x_rdata = mem_rdata as captured (ls_rdata also updates on writes; the value is don't-care).
  - Then either grant the next request (mem_req stays 1 with new fields) or go to IDLE with mem_req=0.
- Latency: request in IDLE → gnt + mem_req 1 cycle later; mem_ack → rvalid 1 cycle later.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each LS grant while if_req=1.
  - Cleared on IF grant or when if_req=0.
- Simultaneous if_req and ls_req with starve_cnt < STARVE_MAX: LS wins.
- A requester whose req drops before gnt is not served; no gnt is issued.
- mem_ack while IDLE: ignored.
- rdata holds its last value when rvalid=0.
- IF and LS rvalid are never asserted in the same cycle.

Optional Feature:
- Macro: FETCH_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY states and is cleared on grant.
  - If TIMEOUT cycles pass without mem_ack: mem_req drops, x_rvalid and err pulse together, x_rdata = 0, state → IDLE.
  - A mem_ack arriving after the abort is ignored.
- Undefined: no counter; BUSY waits indefinitely; err is tied 0.

Test Plan:
- Reset then if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req with rdata=0x12345678 → if_gnt in cycle 1, mem_addr=0x100, mem_be=4'hF, if_rvalid with if_rdata=0x12345678 one cycle after ack.
- if_req and ls_req both asserted in the same cycle, ls_we=1, ls_addr=0x200, ls_wdata=0xDEADBEEF, be=4'h3 → LS granted first with mem_we=1, mem_be=4'h3; IF granted on the LS ack cycle (back-to-back, mem_req never drops).
- ls_req held continuously, if_req held, STARVE_MAX=4, mem_ack every cycle → exactly 4 LS grants, then 1 IF grant, then the counter restarts.
- rst asserted while BUSY_LS with no ack → mem_req=0 next cycle; no ls_rvalid; later requests served normally.
- mem_ack held high in IDLE with no requests → no gnt, no rvalid, outputs stay 0.
- With FETCH_BUS_ARB_TIMEOUT_EN, TIMEOUT=64, IF read never acked → at cycle 64 after grant, if_rvalid=1, err=1, if_rdata=0, mem_req=0; a late mem_ack is ignored.
